// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I MEM/WB pipeline register, load extension, writeback mux and retire counter
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_m,
    input  logic             regwrite_m,
    input  logic [1:0]       result_src_m,
    input  logic [2:0]       funct3_m,
    input  logic [XLEN-1:0]  alu_result_m,
    input  logic [XLEN-1:0]  read_data_m,
    input  logic [XLEN-1:0]  pc_plus4_m,
    input  logic [XLEN-1:0]  imm_m,
    input  logic [4:0]       rd_m,
    input  logic             stall_w,
    input  logic             flush_w,
    output logic             we3,
    output logic [4:0]       a3,
    output logic [XLEN-1:0]  wd3,
    output logic             fwd_en,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             load_fault,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic             valid_q,    valid_d;
    logic             regwrite_q, regwrite_d;
    logic [1:0]       src_q,      src_d;
    logic [2:0]       funct3_q,   funct3_d;
    logic [1:0]       off_q,      off_d;
    logic [XLEN-1:0]  alu_q,      alu_d;
    logic [XLEN-1:0]  rdata_q,    rdata_d;
    logic [XLEN-1:0]  pc4_q,      pc4_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [4:0]       rd_q,       rd_d;
    logic [CNT_W-1:0] instret_q,  instret_d;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [XLEN-1:0]  load_value;
    logic             load_reserved;
    logic [XLEN-1:0]  result;

    // Flush only needs to kill valid; the payload fields are don't-care afterwards.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        src_d      = src_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        if (flush_w) begin
            valid_d = 1'b0;
        end else if (!stall_w) begin
            valid_d    = valid_m;
            regwrite_d = regwrite_m;
            src_d      = result_src_m;
            funct3_d   = funct3_m;
            off_d      = alu_result_m[1:0];
            alu_d      = alu_result_m;
            rdata_d    = read_data_m;
            pc4_d      = pc_plus4_m;
            imm_d      = imm_m;
            rd_d       = rd_m;
        end
    end

    // An instruction retires on the edge where it leaves the stage, so a stall defers the count.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !stall_w) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            src_q      <= 2'b00;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            rd_q       <= 5'd0;
            instret_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            src_q      <= src_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        load_byte = 8'h00;
        case (off_q)
            2'd0:    load_byte = rdata_q[7:0];
            2'd1:    load_byte = rdata_q[15:8];
            2'd2:    load_byte = rdata_q[23:16];
            default: load_byte = rdata_q[31:24];
        endcase
    end

    // Halfword select ignores off[0]; misaligned halfwords are not split across lanes.
    assign load_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_value    = '0;
        load_reserved = 1'b0;
        case (funct3_q)
            F3_LB:   load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
            F3_LH:   load_value = {{(XLEN-16){load_half[15]}}, load_half};
            F3_LW:   load_value = rdata_q;
            F3_LBU:  load_value = {{(XLEN-8){1'b0}}, load_byte};
            F3_LHU:  load_value = {{(XLEN-16){1'b0}}, load_half};
            default: load_reserved = 1'b1;
        endcase
    end

    always_comb begin
        result = alu_q;
        case (src_q)
            SRC_ALU:  result = alu_q;
            SRC_LOAD: result = load_value;
            SRC_PC4:  result = pc4_q;
            SRC_IMM:  result = imm_q;
            default:  result = alu_q;
        endcase
    end

    assign we3        = valid_q & regwrite_q & (rd_q != 5'd0);
    assign a3         = rd_q;
    assign wd3        = result;
    assign fwd_en     = we3;
    assign fwd_rd     = a3;
    assign fwd_data   = wd3;
    assign load_fault = valid_q & (src_q == SRC_LOAD) & load_reserved;
    assign instret    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a behavioural writeback model
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_m, regwrite_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m, imm_m;
    logic [4:0]  rd_m;
    logic        stall_w, flush_w;
    logic        we3, fwd_en, load_fault;
    logic [4:0]  a3, fwd_rd;
    logic [31:0] wd3, fwd_data;
    logic [63:0] instret;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the instruction held in writeback
    logic        m_v, m_known, m_rw;
    logic [1:0]  m_src;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_rdata, m_pc4, m_imm;
    logic [4:0]  m_rd;
    logic [63:0] m_instret;

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .pc_plus4_m(pc_plus4_m), .imm_m(imm_m), .rd_m(rd_m),
        .stall_w(stall_w), .flush_w(flush_w),
        .we3(we3), .a3(a3), .wd3(wd3),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_fault(load_fault), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        byte     sb;
        shortint sh;
        logic [7:0]  ub;
        logic [15:0] uh;
        ub = 8'(w >> (8 * off));
        uh = 16'(w >> (16 * off[1]));
        sb = ub;
        sh = uh;
        case (f3)
            3'd0:    return 32'(sb);
            3'd1:    return 32'(sh);
            3'd2:    return w;
            3'd4:    return 32'(ub);
            3'd5:    return 32'(uh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        case (m_src)
            2'd0:    return m_alu;
            2'd1:    return ref_load(m_rdata, m_alu[1:0], m_f3);
            2'd2:    return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    task automatic model_reset();
        m_v = 0; m_known = 1; m_rw = 0; m_src = 0; m_f3 = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0; m_rd = 0; m_instret = 0;
    endtask

    task automatic model_edge();
        if (m_v && !stall_w) m_instret = m_instret + 1;
        if (flush_w) begin
            m_v = 0;
            m_known = 0;
        end else if (!stall_w) begin
            m_v = valid_m; m_rw = regwrite_m; m_src = result_src_m; m_f3 = funct3_m;
            m_alu = alu_result_m; m_rdata = read_data_m; m_pc4 = pc_plus4_m;
            m_imm = imm_m; m_rd = rd_m; m_known = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_we, exp_lf;
        exp_we = m_v && m_rw && (m_rd != 0);
        exp_lf = m_v && (m_src == 2'd1) && (m_f3 inside {3'd3, 3'd6, 3'd7});
        chk({tag, ".we3"}, 64'(we3), 64'(exp_we));
        chk({tag, ".fwd_en"}, 64'(fwd_en), 64'(exp_we));
        chk({tag, ".load_fault"}, 64'(load_fault), 64'(exp_lf));
        chk({tag, ".instret"}, instret, m_instret);
        if (m_known) begin
            chk({tag, ".a3"}, 64'(a3), 64'(m_rd));
            chk({tag, ".wd3"}, 64'(wd3), 64'(ref_result()));
            chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(m_rd));
            chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(ref_result()));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic [1:0] src,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic [4:0] rd);
        valid_m = v; regwrite_m = rw; result_src_m = src; funct3_m = f3;
        alu_result_m = alu; read_data_m = rdata; rd_m = rd;
        pc_plus4_m = $urandom; imm_m = $urandom;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] exp);
        set_instr(1, 1, 2'b01, f3, {$urandom_range(0, 1023), 20'h0, off}, 32'h80FF7F01, 5'd7);
        step(tag);
        chk({tag, ".const"}, 64'(wd3), 64'(exp));
    endtask

    initial begin
        rst = 0;
        valid_m = 0; regwrite_m = 0; result_src_m = 0; funct3_m = 0;
        alu_result_m = 0; read_data_m = 0; pc_plus4_m = 0; imm_m = 0; rd_m = 0;
        stall_w = 0; flush_w = 0;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.wd3", 64'(wd3), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1;

        set_instr(1, 1, 2'b00, 3'd0, 32'h1234, 32'h0, 5'd5);
        step("alu");
        chk("alu.we3c", 64'(we3), 64'd1);
        chk("alu.wd3c", 64'(wd3), 64'h1234);
        set_instr(0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0);
        step("alu_retire");
        chk("alu.instret", instret, 64'd1);

        load_case("lb3", 3'd0, 2'd3, 32'hFFFFFF80);
        load_case("lbu2", 3'd4, 2'd2, 32'h000000FF);
        load_case("lh2", 3'd1, 2'd2, 32'hFFFF80FF);
        load_case("lhu1", 3'd5, 2'd1, 32'h00007F01);
        load_case("lw3", 3'd2, 2'd3, 32'h80FF7F01);

        set_instr(1, 1, 2'b00, 3'd0, 32'hDEAD, 32'h0, 5'd0);
        step("x0");
        chk("x0.we3c", 64'(we3), 64'd0);

        set_instr(1, 1, 2'b00, 3'd0, 32'hABCD, 32'h0, 5'd9);
        step("hold_cap");
        stall_w = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1, 1, 2'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
            step("stall");
            chk("stall.we3c", 64'(we3), 64'd1);
            chk("stall.wd3c", 64'(wd3), 64'hABCD);
        end
        flush_w = 1;
        step("stall_flush");
        chk("stall_flush.we3c", 64'(we3), 64'd0);
        stall_w = 0; flush_w = 0;

        set_instr(1, 1, 2'b01, 3'd3, 32'h0, 32'h12345678, 5'd4);
        step("reserved");
        chk("reserved.lfc", 64'(load_fault), 64'd1);
        chk("reserved.wd3c", 64'(wd3), 64'd0);
        set_instr(0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0);
        step("reserved_after");

        for (int i = 0; i < 400; i++) begin
            set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
                      3'($urandom), $urandom, $urandom, 5'($urandom));
            stall_w = ($urandom_range(0, 3) == 0);
            flush_w = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        stall_w = 0; flush_w = 0;

        set_instr(1, 1, 2'b10, 3'd0, 32'h0, 32'h0, 5'd12);
        step("pre_rst");
        chk("pre_rst.we3c", 64'(we3), 64'd1);
        #2;
        rst = 0;
        #1;
        chk("async_rst.we3", 64'(we3), 64'd0);
        chk("async_rst.a3", 64'(a3), 64'd0);
        chk("async_rst.wd3", 64'(wd3), 64'd0);
        chk("async_rst.instret", instret, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1;
        set_instr(1, 1, 2'b11, 3'd0, 32'h0, 32'h0, 5'd3);
        step("post_rst");
        set_instr(0, 0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0);
        step("post_rst_retire");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage of the pipelined RV32I core. Registers the memory-stage results in a MEM/WB pipeline register and extends load data by size and sign. It selects the result source and drives the register file write port (write enable, address, data). It also exports the same write as a forwarding source for the execute stage and keeps a retired-instruction counter.

## Interface
- XLEN, 32, datapath width
- CNT_W, 64, width of retired-instruction counter
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_m  in  1  memory-stage slot holds a real instruction
- regwrite_m  in  1  instruction writes rd
- result_src_m  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- funct3_m  in  3  load size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- alu_result_m  in  XLEN  ALU result; bits [1:0] are the load byte offset
- read_data_m  in  XLEN  raw aligned word from data memory
- pc_plus4_m  in  XLEN  PC+4
- imm_m  in  XLEN  extended immediate
- rd_m  in  5  destination register
- stall_w  in  1  hold MEM/WB register
- flush_w  in  1  kill the instruction entering MEM/WB
- we3  out  1  register file write enable
- a3  out  5  register file write address
- wd3  out  XLEN  register file write data
- fwd_en  out  1  forwarding valid (equals we3)
- fwd_rd  out  5  forwarding register (equals a3)
- fwd_data  out  XLEN  forwarding data (equals wd3)
- load_fault  out  1  registered instruction is a load with reserved funct3
- instret  out  CNT_W  count of retired instructions

## Operation
- MEM/WB register fields: valid_w, regwrite_w, result_src_w, funct3_w, off_w (alu_result_m[1:0]), alu_w, rdata_w, pc4_w, imm_w, rd_w.
- Update on every rising clk edge, in priority order:
  - flush_w=1: valid_w←0; the other fields are don't-care.
  - else stall_w=1: hold all fields.
  - else: capture all *_m inputs; valid_w←valid_m.
- Load extension, from rdata_w, off_w and funct3_w:
  - LB/LBU: select byte off_w, then sign- or zero-extend.
  - LH/LHU: select halfword off_w[1] (off_w[0] ignored), then sign- or zero-extend.
  - LW: full word; off_w ignored.
  - funct3 011/110/111: load value is 0, and load_fault=valid_w&(result_src_w==01).
- Result mux, by result_src_w: ALU, load value, PC+4, immediate.
- we3 = valid_w & regwrite_w & (rd_w≠0). Writes to x0 are always suppressed.
- a3=rd_w and wd3=result, driven even when we3=0.
- instret increments by 1 on each edge where valid_w=1 and stall_w=0. It wraps modulo 2^CNT_W.

## Timing
- Reset values (rst low, asynchronous): valid_w=0, all fields 0. Outputs: we3=0, a3=0, wd3=0, fwd_en=0, load_fault=0, instret=0.
- An instruction in the memory stage during cycle N is captured at the end of N. we3/a3/wd3 are valid combinationally during N+1, and the register file writes at the end of N+1. One-cycle stage latency.
- During stall the same write is re-presented each cycle. The rewrite is idempotent. instret counts the instruction once, on the edge where it leaves.
- flush_w and stall_w both high: flush wins and valid_w clears. A held instruction is discarded and not counted.
- Reset asserted mid-operation: the in-flight instruction is dropped and never written. The first capture happens on the first edge after rst deasserts.
- All outputs come from the MEM/WB register plus combinational logic. There are no combinational paths from *_m inputs to outputs.

## Test plan
- Reset release, then ALU op: rd_m=5, result_src_m=00, alu_result_m=0x1234, regwrite_m=1, valid_m=1 -> one cycle later we3=1, a3=5, wd3=0x1234; instret=1 after the next edge.
- Loads with read_data_m=0x80FF7F01:
  - LB off 3 -> wd3=0xFFFFFF80
  - LBU off 2 -> 0x000000FF
  - LH off 2 -> 0xFFFF80FF
  - LHU off 1 -> 0x00007F01
  - LW off 3 -> 0x80FF7F01
- Write to x0: rd_m=0, regwrite_m=1 -> we3=0, fwd_en=0; instret still increments.
- Stall then flush: hold an instruction with stall_w=1 for 3 cycles -> we3 stays 1 with stable a3/wd3 and instret unchanged. Then assert flush_w and stall_w together -> we3=0 and instret unchanged.
- Reserved load funct3=011, result_src_m=01 -> load_fault=1 and wd3=0 for one cycle.
- rst pulled low while we3=1 -> we3, a3, wd3 and instret go to 0 immediately, without waiting for a clock edge.
